// File: rtl/seq_mantissa_divider.sv
// Radix-2 restoring divider for floating-point mantissas with implicit leading 1.
// Produces a normalised WIDTH-bit quotient fraction plus exponent-adjust and sticky flags.
module seq_mantissa_divider #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] m2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m3,
  output logic             decrement_exponent,
  output logic             sticky
);

  localparam int QW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]    d_q, d_d;
  logic [WIDTH:0]    v_q, v_d;
  logic [QW-1:0]     rem_q, rem_d;
  logic [QW-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]  m3_q, m3_d;
  logic              dec_q, dec_d;
  logic              sticky_q, sticky_d;

  // One restoring step; the first step divides D itself, later steps shift in zeros.
  logic [QW-1:0]     shifted;
  logic [QW-1:0]     divisor_ext;
  logic [QW-1:0]     rem_step;
  logic [QW-1:0]     quo_step;
  logic              q_bit;
  logic              rem_nz;

  always_comb begin
    divisor_ext = {1'b0, v_q};
    shifted     = (cnt_q == '0) ? {1'b0, d_q} : (rem_q << 1);
    q_bit       = (shifted >= divisor_ext);
    rem_step    = q_bit ? (shifted - divisor_ext) : shifted;
    quo_step    = (quo_q << 1) | QW'(q_bit);
    rem_nz      = |rem_step;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    v_d      = v_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    m3_d     = m3_q;
    dec_d    = dec_q;
    sticky_d = sticky_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            d_d     = {1'b1, m1};
            v_d     = {1'b1, m2};
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = DIVIDE;
          end
        end
        DIVIDE: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            // Quotient lies in [1,4) scaled; top bit clear means it was below 2.0 relative to D<<W.
            if (quo_step[QW-1]) begin
              m3_d     = quo_step[WIDTH:1];
              dec_d    = 1'b0;
              sticky_d = quo_step[0] | rem_nz;
            end else begin
              m3_d     = quo_step[WIDTH-1:0];
              dec_d    = 1'b1;
              sticky_d = rem_nz;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      d_q      <= '0;
      v_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      m3_q     <= '0;
      dec_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      v_q      <= v_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      m3_q     <= m3_d;
      dec_q    <= dec_d;
      sticky_q <= sticky_d;
    end
  end

  assign in_ready           = (state_q == IDLE);
  assign out_valid          = (state_q == DONE);
  assign m3                 = m3_q;
  assign decrement_exponent = dec_q;
  assign sticky             = sticky_q;

endmodule

// File: tb/tb_seq_mantissa_divider.sv
// Directed bench for seq_mantissa_divider (WIDTH=24): quotient values, latency,
// output hold under back-pressure, flush and asynchronous reset behaviour.
module tb_seq_mantissa_divider;

  localparam int W = 24;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] m1;
  logic [W-1:0] m2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] m3;
  logic         decrement_exponent;
  logic         sticky;

  int checks   = 0;
  int failures = 0;

  seq_mantissa_divider #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .m1                 (m1),
    .m2                 (m2),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .m3                 (m3),
    .decrement_exponent (decrement_exponent),
    .sticky             (sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, measure latency, optionally stall in DONE, then consume it.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] em3, input logic edec, input logic est,
                       input int hold, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
    m1 = a; m2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    m1 = ~a; m2 = ~b;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd26);
    check({tag, "_m3"}, 32'(m3), 32'(em3));
    check({tag, "_dec"}, 32'(decrement_exponent), 32'(edec));
    check({tag, "_sticky"}, 32'(sticky), 32'(est));
    $display("op %s: m1=%06h m2=%06h -> m3=%06h dec=%0b sticky=%0b cycles=%0d",
             tag, a, b, m3, decrement_exponent, sticky, n);
    for (int i = 0; i < hold; i++) begin
      if (i == 4) begin
        m1 = 24'h123456; m2 = 24'h654321; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_out"}, {7'd0, sticky, m3}, {7'd0, est, em3});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release_idle"}, 32'(in_ready), 32'd1);
    check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
    if (hold > 0) begin
      @(posedge clk); #1;
      check({tag, "_no_queue"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m1 = '0; m2 = '0;
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_m3", 32'(m3), 32'd0);
    check("reset_dec", 32'(decrement_exponent), 32'd0);
    check("reset_sticky", 32'(sticky), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Expected values from Q = floor(((1.m1)<<25)/(1.m2)) worked by hand.
    do_op(24'h000000, 24'h000000, 24'h000000, 1'b0, 1'b0, 0, "one_over_one");
    do_op(24'h000000, 24'h800000, 24'h555555, 1'b1, 1'b1, 0, "one_over_1p5");
    do_op(24'h000000, 24'h400000, 24'h999999, 1'b1, 1'b1, 0, "one_over_1p25");
    do_op(24'h400000, 24'h000000, 24'h400000, 1'b0, 1'b0, 0, "1p25_over_one");
    do_op(24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0, 0, "max_over_one");
    do_op(24'h000000, 24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 0, "one_over_max");
    do_op(24'hFFFFFF, 24'h800000, 24'h555554, 1'b0, 1'b1, 0, "max_over_1p5");
    do_op(24'h800000, 24'h000000, 24'h800000, 1'b0, 1'b0, 10, "hold_1p5");

    // Flush during DIVIDE: the aborted operation never produces a result.
    m1 = 24'h800000; m2 = 24'h400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
    end
    check("flush_in_divide", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 32'(in_ready), 32'd1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    do_op(24'h000000, 24'h400000, 24'h999999, 1'b1, 1'b1, 0, "after_flush");

    // Asynchronous reset mid-DIVIDE; previous result registers are non-zero here.
    m1 = 24'hFFFFFF; m2 = 24'h800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("areset_in_ready", 32'(in_ready), 32'd1);
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_m3", 32'(m3), 32'd0);
    check("areset_dec", 32'(decrement_exponent), 32'd0);
    check("areset_sticky", 32'(sticky), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(24'h400000, 24'h000000, 24'h400000, 1'b0, 1'b0, 0, "after_reset");

    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
